// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state encoding and datapath width for the ALU result stage
package alu_pkg;
  localparam int REG_SIZE = 32;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_ROL = 4'b0110;
  localparam logic [3:0] OP_ROR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_NEG = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
endpackage

// File: rtl/alu_latency_lut.sv
// alu_latency_lut: maps an opcode to its settle cycle count (mul/div are multicycle paths)
module alu_latency_lut import alu_pkg::*; #(
  parameter int BASE_CYCLES = 1,
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 8,
  parameter int CW          = 4
) (
  input  logic [3:0]    op,
  output logic [CW-1:0] lat
);
  assign lat = op == OP_MUL ? CW'(MUL_CYCLES) : op == OP_DIV ? CW'(DIV_CYCLES) : CW'(BASE_CYCLES);
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: sequences operands into the combinational ALU and captures its settled result into Z
module alu_result_stage #(
  parameter int REG_SIZE    = 32,
  parameter int BASE_CYCLES = 1,
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [REG_SIZE-1:0]   bus_in,
  input  logic                  y_in,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [2*REG_SIZE-1:0] alu_result,
  output logic [3:0]            alu_ctrl,
  output logic [REG_SIZE-1:0]   alu_a,
  output logic [REG_SIZE-1:0]   alu_b,
  input  logic                  z_lo_out,
  input  logic                  z_hi_out,
  output logic [REG_SIZE-1:0]   bus_out,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic                  zero_flag,
  output logic                  neg_flag
);
  import alu_pkg::*;
  localparam int MAX_CYC = MUL_CYCLES > DIV_CYCLES ? (MUL_CYCLES > BASE_CYCLES ? MUL_CYCLES : BASE_CYCLES)
                                                   : (DIV_CYCLES > BASE_CYCLES ? DIV_CYCLES : BASE_CYCLES);
  localparam int CW = $clog2(MAX_CYC) + 1;
  state_t state;
  logic [CW-1:0] cnt, lat;
  logic [REG_SIZE-1:0] y, b;
  logic [2*REG_SIZE-1:0] z, z_next;
  logic wide, bad, zero_next, neg_next;
  alu_latency_lut #(.BASE_CYCLES(BASE_CYCLES), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CW(CW))
    u_lut (.op(op), .lat(lat));
  always_comb begin
    wide      = alu_ctrl == OP_MUL || alu_ctrl == OP_DIV;
    bad       = alu_ctrl[3:2] == 2'b11;
    z_next    = bad ? '0 : wide ? alu_result : {{REG_SIZE{1'b0}}, alu_result[REG_SIZE-1:0]};
    zero_next = wide ? z_next == '0 : z_next[REG_SIZE-1:0] == '0;
    neg_next  = wide ? z_next[2*REG_SIZE-1] : z_next[REG_SIZE-1];
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      y         <= '0;
      b         <= '0;
      z         <= '0;
      alu_ctrl  <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (y_in) y <= bus_in;
          if (start) begin
            alu_ctrl <= op;
            b        <= bus_in;
            cnt      <= lat - 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            z         <= z_next;
            zero_flag <= zero_next;
            neg_flag  <= neg_next;
            done      <= 1'b1;
            illegal   <= bad;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy    = state != IDLE;
  assign alu_a   = y;
  assign alu_b   = b;
  assign bus_out = z_lo_out ? z[REG_SIZE-1:0] : z_hi_out ? z[2*REG_SIZE-1:REG_SIZE] : '0;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed checks of latency, capture, flags, start/y_in gating and reset abort
module tb_alu_result_stage;
  logic clk = 1'b0;
  logic clr, y_in, start, z_lo_out, z_hi_out;
  logic [31:0] bus_in, bus_out, alu_a, alu_b;
  logic [3:0] op, alu_ctrl;
  logic [63:0] alu_result;
  logic busy, done, illegal, zero_flag, neg_flag;
  int checks = 0, failures = 0, dones, done_at;
  always #5 clk = ~clk;
  alu_result_stage dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .y_in(y_in), .start(start), .op(op),
    .alu_result(alu_result), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .z_lo_out(z_lo_out), .z_hi_out(z_hi_out), .bus_out(bus_out), .busy(busy),
    .done(done), .illegal(illegal), .zero_flag(zero_flag), .neg_flag(neg_flag)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic load_y(input logic [31:0] v);
    bus_in = v; y_in = 1'b1;
    tick;
    y_in = 1'b0;
  endtask
  task automatic launch(input logic [3:0] o, input logic [31:0] bv, input logic [63:0] res);
    op = o; bus_in = bv; alu_result = res; start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic sel(input logic lo, input logic hi);
    z_lo_out = lo; z_hi_out = hi;
    #1;
  endtask
  initial begin
    clr = 1'b1; y_in = 1'b0; start = 1'b0; op = 4'h0; bus_in = '0; alu_result = '0;
    z_lo_out = 1'b0; z_hi_out = 1'b0;
    tick; tick;
    clr = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {zero_flag, neg_flag, illegal}, 0);
    chk("rst_regs", {alu_a, alu_b}, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    sel(1, 0); chk("rst_z_lo", bus_out, 0);
    sel(0, 0); chk("bus_idle", bus_out, 0);
    // add: LAT=1, done after E1
    load_y(32'd5);
    launch(4'b0010, 32'd7, 64'd12);
    chk("add_busy", busy, 1);
    chk("add_done_e0", done, 0);
    chk("add_ops", {alu_a, alu_b}, {32'd5, 32'd7});
    chk("add_ctrl", alu_ctrl, 4'b0010);
    tick;
    chk("add_done", done, 1);
    sel(1, 0); chk("add_z_lo", bus_out, 32'hC);
    sel(0, 1); chk("add_z_hi", bus_out, 0);
    chk("add_flags", {zero_flag, neg_flag, illegal}, 0);
    tick;
    chk("add_idle", {busy, done}, 0);
    // mul: LAT=4, signed -1 * 2
    load_y(32'hFFFF_FFFF);
    launch(4'b1000, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (done) dones++;
      chk("mul_busy", busy, 1);
    end
    chk("mul_early_done", dones, 0);
    tick;
    chk("mul_done", done, 1);
    sel(0, 1); chk("mul_z_hi", bus_out, 32'hFFFF_FFFF);
    sel(1, 1); chk("mul_lo_prio", bus_out, 32'hFFFF_FFFE);
    chk("mul_flags", {zero_flag, neg_flag}, 2'b01);
    tick;
    // sub 3-3 then ror with junk upper half
    load_y(32'd3);
    launch(4'b0011, 32'd3, 64'd0);
    tick;
    chk("sub_done", done, 1);
    chk("sub_flags", {zero_flag, neg_flag}, 2'b10);
    tick;
    launch(4'b0111, 32'd1, 64'hDEAD_BEEF_8000_0001);
    tick;
    chk("ror_done", done, 1);
    sel(0, 1); chk("ror_z_hi", bus_out, 0);
    sel(1, 0); chk("ror_z_lo", bus_out, 32'h8000_0001);
    chk("ror_flags", {zero_flag, neg_flag}, 2'b01);
    tick;
    // div with ignored starts, y_in while busy, start in DONE cycle
    load_y(32'd100);
    launch(4'b1001, 32'd7, 64'h0000_0002_0000_000E);
    dones = 0; done_at = -1;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (done) begin dones++; done_at = k; end
      start = (k == 1 || k == 4 || k == 8);
      y_in = start;
      op = 4'b0010; bus_in = 32'd55;
    end
    chk("div_done_cnt", dones, 1);
    chk("div_done_at", done_at, 8);
    chk("div_ops", {alu_a, alu_b}, {32'd100, 32'd7});
    chk("div_ctrl", alu_ctrl, 4'b1001);
    chk("div_idle", busy, 0);
    sel(0, 1); chk("div_z_hi", bus_out, 32'd2);
    sel(1, 0); chk("div_z_lo", bus_out, 32'hE);
    chk("div_flags", {zero_flag, neg_flag}, 0);
    // illegal opcode
    launch(4'b1101, 32'd1, 64'd123);
    tick;
    chk("ill_done", {done, illegal}, 2'b11);
    sel(1, 0); chk("ill_z_lo", bus_out, 0);
    sel(0, 1); chk("ill_z_hi", bus_out, 0);
    chk("ill_flags", {zero_flag, neg_flag}, 2'b10);
    tick;
    chk("ill_clear", {done, illegal}, 0);
    // give Z a nonzero value, then abort a div with clr
    launch(4'b0010, 32'd4, 64'd9);
    tick; tick;
    sel(1, 0); chk("pre_abort_z", bus_out, 32'd9);
    load_y(32'd77);
    launch(4'b1001, 32'd3, 64'd50);
    tick; tick;
    chk("abort_busy_pre", busy, 1);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_z", bus_out, 0);
    chk("abort_regs", {alu_a, alu_b, 28'd0, alu_ctrl}, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
